lcd_bus_sequencer: RTL and testbench
====================================

// Module: lcd_bus_sequencer
// PURPOSE
//  Owns the ILI9341-style 8080 parallel LCD bus (csx/dcx/wrx/rdx/resx/data) behind lcd_controller_0.
//  Arbitrates between a CPU command/parameter port and a DMA pixel stream port.
//  Sequences each word as a timed write cycle and runs the panel hardware-reset sequence.
//  Sits between the Avalon-facing register/DMA logic and the exported LCD pins in soc_system.
// PARAMETERS
//  DATA_W        16      LCD data bus width
//  WR_LOW_CYC    2       clk cycles wrx held low per word (>=1)
//  WR_HIGH_CYC   2       clk cycles wrx held high after rising edge, data held (>=1)
//  RST_LOW_CYC   500000  clk cycles resx held low in reset sequence (>=1)
//  RST_WAIT_CYC  6000000 clk cycles after resx release before bus is usable (>=1)
// PORTS
//  clk           in   1       system clock
//  reset         in   1       asynchronous, active-high reset
//  cmd_valid     in   1       CPU word available
//  cmd_ready     out  1       CPU word accepted this cycle (valid&&ready)
//  cmd_dc        in   1       0 = command, 1 = parameter; drives lcd_dcx
//  cmd_data      in   DATA_W  CPU word
//  pix_valid     in   1       pixel word available
//  pix_ready     out  1       pixel word accepted this cycle
//  pix_data      in   DATA_W  pixel word (lcd_dcx=1)
//  pix_last      in   1       qualifies last pixel of a burst
//  hw_reset_req  in   1       single-cycle pulse: request panel reset sequence
//  lcd_csx/lcd_dcx/lcd_wrx/lcd_rdx/lcd_resx  out 1 each   panel control pins
//  lcd_data      out  DATA_W  panel data bus
//  busy          out  1       high in any state except IDLE
//  grant_pix     out  1       1 = pixel port owns the current/last word
// BEHAVIOUR
//  Reset values: lcd_resx=0, lcd_csx=1, lcd_wrx=1, lcd_rdx=1 (constant, reads unsupported), lcd_dcx=0,
//   lcd_data=0, cmd_ready=0, pix_ready=0, busy=1, grant_pix=0; FSM=RST_LOW, counters=0, lock=0, rst_pend=0.
//  FSM: RST_LOW -> RST_WAIT -> IDLE -> SETUP -> WR_LOW -> WR_HIGH -> IDLE.
//  RST_LOW: resx=0, csx=1 for RST_LOW_CYC cycles. RST_WAIT: resx=1 for RST_WAIT_CYC cycles.
//  IDLE priority: rst_pend > locked pixel burst > cmd_valid > pix_valid.
//   rst_pend set: clear rst_pend and lock, go RST_LOW; no ready asserted.
//   otherwise: assert the winner's ready for exactly 1 cycle (combinational on valid), latch data/dc,
//   set grant_pix, go SETUP.
//  SETUP (1 cycle): csx=0, dcx and data driven, wrx=1. WR_LOW: wrx=0 for WR_LOW_CYC cycles.
//  WR_HIGH: wrx=1, data/dcx/csx held for WR_HIGH_CYC cycles, then IDLE.
//  Word period = 2+WR_LOW_CYC+WR_HIGH_CYC cycles incl. IDLE accept cycle.
//  csx returns to 1 in IDLE unless a burst is locked (csx stays 0 between burst words).
//  hw_reset_req: latched into rst_pend in any state; current word completes first; repeat pulses merge.
//  Async reset mid-word: pins go to reset values immediately, word discarded, sequence restarts.
//  Counters sized $clog2(max param)+1; terminal count compare, no wrap.
// CONFIGURATION
//  LCD_BURST_LOCK_EN defined: accepted pixel word with pix_last=0 sets lock; lock cleared when
//   pix_last=1 word accepted or rst_pend serviced; while locked cmd_valid is ignored.
//  Not defined: no lock; per-word arbitration, cmd wins every IDLE where both are valid.
// TESTING (WR_LOW_CYC=2, WR_HIGH_CYC=2, RST_LOW_CYC=4, RST_WAIT_CYC=8)
//  Release reset -> resx=0 for 4 cycles, resx=1 + busy for 8 more, then busy=0, csx=1.
//  cmd 0x002C dc=0 -> cmd_ready 1 cycle; csx=0,dcx=0,data=0x002C; wrx low 2 cycles; back IDLE after 6 cycles.
//  cmd and pix valid same IDLE cycle -> cmd_ready=1, pix_ready=0, grant_pix=0.
//  LOCK_EN: 3-word pixel burst with cmd_valid high throughout -> 3 pix words back-to-back, csx=0 throughout, then cmd.
//  No LOCK_EN: same stimulus -> cmd word wins each IDLE; pixels wait until cmd_valid drops.
//  hw_reset_req during WR_LOW -> word completes (wrx rises), then RST_LOW; no ready during 12-cycle sequence.

Source files
------------

// File: rtl/lcd_bus_sequencer.sv
// rtl/lcd_bus_sequencer.sv - 8080-style LCD bus sequencer: CPU/pixel arbitration, timed write cycles, panel reset sequence
// Optional feature macro: LCD_BURST_LOCK_EN (pixel bursts hold the bus until pix_last)
module lcd_bus_sequencer #(
    parameter int DATA_W       = 16,
    parameter int WR_LOW_CYC   = 2,
    parameter int WR_HIGH_CYC  = 2,
    parameter int RST_LOW_CYC  = 500000,
    parameter int RST_WAIT_CYC = 6000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_dc,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic [DATA_W-1:0] pix_data,
    input  logic              pix_last,
    input  logic              hw_reset_req,
    output logic              lcd_csx,
    output logic              lcd_dcx,
    output logic              lcd_wrx,
    output logic              lcd_rdx,
    output logic              lcd_resx,
    output logic [DATA_W-1:0] lcd_data,
    output logic              busy,
    output logic              grant_pix
);

    localparam int MAX_AB  = (WR_LOW_CYC > WR_HIGH_CYC) ? WR_LOW_CYC : WR_HIGH_CYC;
    localparam int MAX_CD  = (RST_LOW_CYC > RST_WAIT_CYC) ? RST_LOW_CYC : RST_WAIT_CYC;
    localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CW      = $clog2(MAX_CYC) + 1;

    localparam logic [CW-1:0] RST_LOW_LAST  = CW'(RST_LOW_CYC - 1);
    localparam logic [CW-1:0] RST_WAIT_LAST = CW'(RST_WAIT_CYC - 1);
    localparam logic [CW-1:0] WR_LOW_LAST   = CW'(WR_LOW_CYC - 1);
    localparam logic [CW-1:0] WR_HIGH_LAST  = CW'(WR_HIGH_CYC - 1);

    typedef enum logic [2:0] {
        S_RST_LOW,
        S_RST_WAIT,
        S_IDLE,
        S_SETUP,
        S_WR_LOW,
        S_WR_HIGH
    } state_t;

    state_t            state, next_state;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] data_q;
    logic              dc_q;
    logic              grant_q;
    logic              lock_q;
    logic              rst_pend_q;
    logic              service_rst;
    logic              take_cmd;
    logic              take_pix;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_RST_LOW;
        else       state <= next_state;
    end

    // Next-state and handshake decode; IDLE arbitration: reset > locked burst > cmd > pix
    always_comb begin
        next_state  = state;
        cmd_ready   = 1'b0;
        pix_ready   = 1'b0;
        service_rst = 1'b0;
        case (state)
            S_RST_LOW:  if (cnt == RST_LOW_LAST)  next_state = S_RST_WAIT;
            S_RST_WAIT: if (cnt == RST_WAIT_LAST) next_state = S_IDLE;
            S_IDLE: begin
                if (rst_pend_q) begin
                    service_rst = 1'b1;
                    next_state  = S_RST_LOW;
                end else if (lock_q) begin
                    if (pix_valid) begin
                        pix_ready  = 1'b1;
                        next_state = S_SETUP;
                    end
                end else if (cmd_valid) begin
                    cmd_ready  = 1'b1;
                    next_state = S_SETUP;
                end else if (pix_valid) begin
                    pix_ready  = 1'b1;
                    next_state = S_SETUP;
                end
            end
            S_SETUP:    next_state = S_WR_LOW;
            S_WR_LOW:   if (cnt == WR_LOW_LAST)  next_state = S_WR_HIGH;
            S_WR_HIGH:  if (cnt == WR_HIGH_LAST) next_state = S_IDLE;
            default:    next_state = S_RST_LOW;
        endcase
    end

    assign take_cmd = cmd_valid && cmd_ready;
    assign take_pix = pix_valid && pix_ready;

    // Phase counter: cleared on every state change and in untimed states, so it never wraps
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                                      cnt <= '0;
        else if (next_state != state || state == S_IDLE || state == S_SETUP) cnt <= '0;
        else                                                            cnt <= cnt + 1'b1;
    end

    // Word latch: data/dc/grant captured on the accept cycle and held through the write cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q  <= '0;
            dc_q    <= 1'b0;
            grant_q <= 1'b0;
        end else if (take_cmd) begin
            data_q  <= cmd_data;
            dc_q    <= cmd_dc;
            grant_q <= 1'b0;
        end else if (take_pix) begin
            data_q  <= pix_data;
            dc_q    <= 1'b1;
            grant_q <= 1'b1;
        end
    end

    // Pending panel reset: repeated requests merge, serviced at the next IDLE
    always_ff @(posedge clk or posedge reset) begin
        if (reset)             rst_pend_q <= 1'b0;
        else if (service_rst)  rst_pend_q <= 1'b0;
        else if (hw_reset_req) rst_pend_q <= 1'b1;
    end

`ifdef LCD_BURST_LOCK_EN
    // Burst lock: set by a non-final pixel word, dropped by the final one or a panel reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset)            lock_q <= 1'b0;
        else if (service_rst) lock_q <= 1'b0;
        else if (take_pix)    lock_q <= ~pix_last;
    end
`else
    logic unused_pix_last;
    assign unused_pix_last = pix_last;

    // No burst lock: every IDLE arbitrates afresh
    always_ff @(posedge clk or posedge reset) begin
        if (reset) lock_q <= 1'b0;
        else       lock_q <= 1'b0;
    end
`endif

    // Pins decode directly from state so an async reset forces them at once
    assign lcd_resx  = (state != S_RST_LOW);
    assign lcd_csx   = !((state == S_SETUP) || (state == S_WR_LOW) || (state == S_WR_HIGH) ||
                         ((state == S_IDLE) && lock_q));
    assign lcd_wrx   = (state != S_WR_LOW);
    assign lcd_rdx   = 1'b1;
    assign lcd_dcx   = dc_q;
    assign lcd_data  = data_q;
    assign busy      = (state != S_IDLE);
    assign grant_pix = grant_q;

endmodule

// File: tb/tb_lcd_bus_sequencer.sv
// tb/tb_lcd_bus_sequencer.sv - directed-vector bench for lcd_bus_sequencer
module tb_lcd_bus_sequencer;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_dc = 1'b0;
    logic [DW-1:0] cmd_data = '0;
    logic          pix_valid = 1'b0;
    logic          pix_ready;
    logic [DW-1:0] pix_data = '0;
    logic          pix_last = 1'b0;
    logic          hw_reset_req = 1'b0;
    logic          lcd_csx, lcd_dcx, lcd_wrx, lcd_rdx, lcd_resx;
    logic [DW-1:0] lcd_data;
    logic          busy, grant_pix;

    int n_vec = 0;
    int n_bad = 0;

    lcd_bus_sequencer #(
        .DATA_W(DW), .WR_LOW_CYC(2), .WR_HIGH_CYC(2), .RST_LOW_CYC(4), .RST_WAIT_CYC(8)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dc(cmd_dc), .cmd_data(cmd_data),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data), .pix_last(pix_last),
        .hw_reset_req(hw_reset_req),
        .lcd_csx(lcd_csx), .lcd_dcx(lcd_dcx), .lcd_wrx(lcd_wrx), .lcd_rdx(lcd_rdx),
        .lcd_resx(lcd_resx), .lcd_data(lcd_data), .busy(busy), .grant_pix(grant_pix)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Walks SETUP, WR_LOW x2, WR_HIGH x2; call just after the posedge that left IDLE
    task automatic word_tail(input string tag, input logic [DW-1:0] d, input logic dc, input logic gp);
        @(negedge clk);
        check({tag, "_setup_csx"}, lcd_csx, 1'b0);
        check({tag, "_setup_wrx"}, lcd_wrx, 1'b1);
        check({tag, "_dcx"}, lcd_dcx, dc);
        check({tag, "_data"}, lcd_data, d);
        check({tag, "_grant"}, grant_pix, gp);
        check({tag, "_ready_gone"}, {cmd_ready, pix_ready}, 2'b00);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check({tag, "_wrlow_wrx"}, lcd_wrx, 1'b0);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check({tag, "_wrhigh_wrx"}, lcd_wrx, 1'b1);
            check({tag, "_wrhigh_csx"}, lcd_csx, 1'b0);
            check({tag, "_wrhigh_data"}, lcd_data, d);
        end
    endtask

    initial begin
        logic [7:0] seq [4];
        string      exp_seq;
        int         nseq;
        int         pidx;
        int         cyc;
        int         rdy_cnt;
        logic       hs_c, hs_p, cmd_started;
        logic       csx_between;

`ifdef LCD_BURST_LOCK_EN
        exp_seq     = "PPPC";
        csx_between = 1'b0;
`else
        exp_seq     = "PCPP";
        csx_between = 1'b1;
`endif

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_resx", lcd_resx, 1'b0);
        check("rst_csx", lcd_csx, 1'b1);
        check("rst_wrx", lcd_wrx, 1'b1);
        check("rst_rdx", lcd_rdx, 1'b1);
        check("rst_dcx", lcd_dcx, 1'b0);
        check("rst_data", lcd_data, 16'h0000);
        check("rst_ready", {cmd_ready, pix_ready}, 2'b00);
        check("rst_busy", busy, 1'b1);
        check("rst_grant", grant_pix, 1'b0);
        @(posedge clk); #1 reset = 1'b0;

        // Panel reset sequence: 4 cycles resx low, 8 cycles wait
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("seq_rstlow_resx", lcd_resx, 1'b0);
            check("seq_rstlow_busy", busy, 1'b1);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("seq_wait_resx", lcd_resx, 1'b1);
            check("seq_wait_busy", busy, 1'b1);
        end
        @(negedge clk);
        check("seq_idle_busy", busy, 1'b0);
        check("seq_idle_csx", lcd_csx, 1'b1);

        // Single command word 0x002C
        @(posedge clk); #1 cmd_valid = 1'b1; cmd_dc = 1'b0; cmd_data = 16'h002C;
        @(negedge clk);
        check("cmd_ready", cmd_ready, 1'b1);
        check("cmd_pix_ready", pix_ready, 1'b0);
        @(posedge clk); #1 cmd_valid = 1'b0;
        word_tail("cmd", 16'h002C, 1'b0, 1'b0);
        @(negedge clk);
        check("cmd_back_idle", busy, 1'b0);
        check("cmd_idle_csx", lcd_csx, 1'b1);

        // Command and pixel valid in the same IDLE cycle
        @(posedge clk); #1
        cmd_valid = 1'b1; cmd_dc = 1'b1; cmd_data = 16'h0036;
        pix_valid = 1'b1; pix_data = 16'hF800; pix_last = 1'b1;
        @(negedge clk);
        check("both_cmd_ready", cmd_ready, 1'b1);
        check("both_pix_ready", pix_ready, 1'b0);
        @(posedge clk); #1 cmd_valid = 1'b0;
        word_tail("both_cmd", 16'h0036, 1'b1, 1'b0);
        @(negedge clk);
        check("both_then_pix_ready", pix_ready, 1'b1);
        @(posedge clk); #1 pix_valid = 1'b0;
        word_tail("both_pix", 16'hF800, 1'b1, 1'b1);
        @(negedge clk);
        check("both_idle", busy, 1'b0);

        // Three-word pixel burst with a command raised behind it
        @(posedge clk); #1
        pix_valid = 1'b1; pix_data = 16'h1000; pix_last = 1'b0;
        pidx = 0; nseq = 0; cyc = 0; cmd_started = 1'b0;
        while (nseq < 4 && cyc < 200) begin
            @(negedge clk);
            hs_c = cmd_valid && cmd_ready;
            hs_p = pix_valid && pix_ready;
            if (hs_p) begin
                if (pidx > 0) check("burst_csx_between", lcd_csx, csx_between);
                seq[nseq] = "P";
                nseq++;
            end
            if (hs_c) begin
                check("burst_cmd_csx", lcd_csx, 1'b1);
                seq[nseq] = "C";
                nseq++;
            end
            @(posedge clk); #1
            if (!cmd_started) begin
                cmd_started = 1'b1;
                cmd_valid = 1'b1; cmd_dc = 1'b0; cmd_data = 16'h002C;
            end
            if (hs_c) cmd_valid = 1'b0;
            if (hs_p) begin
                pidx++;
                pix_valid = (pidx < 3);
                pix_data  = 16'h1000 + 16'(pidx);
                pix_last  = (pidx == 2);
            end
            cyc++;
        end
        check("burst_completed", (nseq == 4), 1'b1);
        for (int k = 0; k < 4; k++) begin
            if (k < nseq) check("burst_order", seq[k], exp_seq[k]);
        end
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (busy && cyc < 50);
        check("burst_idle", busy, 1'b0);

        // Panel reset request during WR_LOW
        @(posedge clk); #1 cmd_valid = 1'b1; cmd_dc = 1'b0; cmd_data = 16'h0011;
        @(negedge clk);
        check("hwr_cmd_ready", cmd_ready, 1'b1);
        @(posedge clk); #1
        cmd_data = 16'h0029;
        pix_valid = 1'b1; pix_data = 16'h07E0; pix_last = 1'b1;
        @(negedge clk);
        check("hwr_setup_csx", lcd_csx, 1'b0);
        @(posedge clk); #1 hw_reset_req = 1'b1;
        @(negedge clk);
        check("hwr_wrlow_wrx", lcd_wrx, 1'b0);
        @(posedge clk); #1 hw_reset_req = 1'b0;
        @(negedge clk);
        check("hwr_wrlow2_wrx", lcd_wrx, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("hwr_wrhigh_wrx", lcd_wrx, 1'b1);
            check("hwr_wrhigh_resx", lcd_resx, 1'b1);
        end
        @(negedge clk);
        check("hwr_idle_no_ready", {cmd_ready, pix_ready}, 2'b00);
        check("hwr_idle_csx", lcd_csx, 1'b1);
        rdy_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (cmd_ready || pix_ready) rdy_cnt++;
            check("hwr_seq_resx", lcd_resx, (i < 4) ? 1'b0 : 1'b1);
        end
        check("hwr_seq_ready_count", rdy_cnt, 0);
        @(negedge clk);
        check("hwr_after_cmd_ready", cmd_ready, 1'b1);
        @(posedge clk); #1 cmd_valid = 1'b0; pix_valid = 1'b0;
        word_tail("hwr_after", 16'h0029, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
